// File: rtl/snn_output_decoder.sv
// Spike-count decoder for the two SNN output neurons: counts spikes over one run,
// picks the winning class at end of run and hands it over on a valid/ready handshake.
module snn_output_decoder #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_start,
    input  logic             opnu1_spike,
    input  logic             opnu2_spike,
    input  logic             hold,
    input  logic             done,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [1:0]       result_class,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic             saturated,
    output logic             timed_out,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);

    state_t            state, state_nxt;
    logic [TO_W-1:0]   to_cnt, to_nxt;
    logic [CNT_W-1:0]  c1_nxt, c2_nxt;
    logic              active, inc1, inc2, hit1, hit2, to_hit, finish;

    function automatic logic [1:0] class_of(input logic [CNT_W-1:0] a,
                                            input logic [CNT_W-1:0] b);
        if (a == '0 && b == '0) return 2'b00;
        else if (a > b)         return 2'b01;
        else if (b > a)         return 2'b10;
        else                    return 2'b11;
    endfunction

    // Next counter values include the current cycle, so a spike arriving with done is scored.
    always_comb begin
        active = (state == COUNT) && !hold;
        inc1   = active && opnu1_spike;
        inc2   = active && opnu2_spike;
        hit1   = inc1 && (count1 == CNT_MAX);
        hit2   = inc2 && (count2 == CNT_MAX);
        c1_nxt = (inc1 && !hit1) ? count1 + 1'b1 : count1;
        c2_nxt = (inc2 && !hit2) ? count2 + 1'b1 : count2;
        to_nxt = active ? to_cnt + 1'b1 : to_cnt;
        to_hit = (TIMEOUT != 0) && active && (to_nxt == TO_LIMIT);
        finish = (state == COUNT) && (done || to_hit);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run_start)    state_nxt = COUNT;
            COUNT:   if (finish)       state_nxt = REPORT;
            REPORT:  if (result_ready) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Result fields persist through REPORT and IDLE; only run_start clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count1       <= '0;
            count2       <= '0;
            to_cnt       <= '0;
            saturated    <= 1'b0;
            timed_out    <= 1'b0;
            result_class <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (run_start) begin
                        count1       <= '0;
                        count2       <= '0;
                        to_cnt       <= '0;
                        saturated    <= 1'b0;
                        timed_out    <= 1'b0;
                        result_class <= 2'b00;
                    end
                end
                COUNT: begin
                    count1 <= c1_nxt;
                    count2 <= c2_nxt;
                    to_cnt <= to_nxt;
                    if (hit1 || hit2)     saturated    <= 1'b1;
                    if (finish)           result_class <= class_of(c1_nxt, c2_nxt);
                    if (to_hit && !done)  timed_out    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result_valid = (state == REPORT);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_snn_output_decoder.sv
// Bench for snn_output_decoder: two instances (small saturating counters / short timeout)
// driven in parallel and checked every cycle against a run-level arithmetic model.
module tb_snn_output_decoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run_start = 1'b0, opnu1_spike = 1'b0, opnu2_spike = 1'b0;
    logic hold = 1'b0, done = 1'b0, result_ready = 1'b0;

    logic       valid_a, busy_a, sat_a, to_a;
    logic [1:0] cls_a;
    logic [3:0] c1_a, c2_a;
    logic       valid_b, busy_b, sat_b, to_b;
    logic [1:0] cls_b;
    logic [7:0] c1_b, c2_b;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 idle, 1 counting, 2 reporting; per instance.
    int m_phase[2], m_c1[2], m_c2[2], m_ticks[2], m_cls[2];
    bit m_sat[2], m_to[2];
    int m_max[2]   = '{15, 255};
    int m_tolim[2] = '{0, 16};

    always #5 clk = ~clk;

    snn_output_decoder #(.CNT_W(4), .TIMEOUT(0), .TO_W(13)) dut_a (
        .clk(clk), .rst(rst), .run_start(run_start),
        .opnu1_spike(opnu1_spike), .opnu2_spike(opnu2_spike),
        .hold(hold), .done(done),
        .result_valid(valid_a), .result_ready(result_ready),
        .result_class(cls_a), .count1(c1_a), .count2(c2_a),
        .saturated(sat_a), .timed_out(to_a), .busy(busy_a)
    );

    snn_output_decoder #(.CNT_W(8), .TIMEOUT(16), .TO_W(5)) dut_b (
        .clk(clk), .rst(rst), .run_start(run_start),
        .opnu1_spike(opnu1_spike), .opnu2_spike(opnu2_spike),
        .hold(hold), .done(done),
        .result_valid(valid_b), .result_ready(result_ready),
        .result_class(cls_b), .count1(c1_b), .count2(c2_b),
        .saturated(sat_b), .timed_out(to_b), .busy(busy_b)
    );

    function automatic int classOf(input int a, input int b);
        if (a == 0 && b == 0) return 0;
        if (a > b)            return 1;
        if (b > a)            return 2;
        return 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_c1[i] = 0; m_c2[i] = 0; m_ticks[i] = 0;
            m_cls[i] = 0; m_sat[i] = 0; m_to[i] = 0;
        end
    endtask

    task automatic modelStep();
        for (int i = 0; i < 2; i++) begin
            case (m_phase[i])
                0: if (run_start) begin
                    m_c1[i] = 0; m_c2[i] = 0; m_ticks[i] = 0;
                    m_sat[i] = 0; m_to[i] = 0; m_cls[i] = 0;
                    m_phase[i] = 1;
                end
                1: begin
                    if (!hold) begin
                        if (opnu1_spike) begin
                            if (m_c1[i] == m_max[i]) m_sat[i] = 1; else m_c1[i]++;
                        end
                        if (opnu2_spike) begin
                            if (m_c2[i] == m_max[i]) m_sat[i] = 1; else m_c2[i]++;
                        end
                        m_ticks[i]++;
                    end
                    if (done) begin
                        m_phase[i] = 2;
                        m_cls[i] = classOf(m_c1[i], m_c2[i]);
                    end else if (!hold && m_tolim[i] != 0 && m_ticks[i] == m_tolim[i]) begin
                        m_phase[i] = 2;
                        m_to[i] = 1;
                        m_cls[i] = classOf(m_c1[i], m_c2[i]);
                    end
                end
                default: if (result_ready) m_phase[i] = 0;
            endcase
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".a.valid"}, valid_a, m_phase[0] == 2);
        check({tag, ".a.busy"},  busy_a,  m_phase[0] != 0);
        check({tag, ".a.count1"}, c1_a, m_c1[0]);
        check({tag, ".a.count2"}, c2_a, m_c2[0]);
        check({tag, ".a.class"}, cls_a, m_cls[0]);
        check({tag, ".a.sat"},   sat_a, m_sat[0]);
        check({tag, ".a.tout"},  to_a,  m_to[0]);
        check({tag, ".b.valid"}, valid_b, m_phase[1] == 2);
        check({tag, ".b.busy"},  busy_b,  m_phase[1] != 0);
        check({tag, ".b.count1"}, c1_b, m_c1[1]);
        check({tag, ".b.count2"}, c2_b, m_c2[1]);
        check({tag, ".b.class"}, cls_b, m_cls[1]);
        check({tag, ".b.sat"},   sat_b, m_sat[1]);
        check({tag, ".b.tout"},  to_b,  m_to[1]);
    endtask

    task automatic applyStimulus(input string tag, input logic s1, input logic s2,
                                 input logic h, input logic d, input logic rs,
                                 input logic rdy);
        opnu1_spike = s1; opnu2_spike = s2; hold = h; done = d;
        run_start = rs; result_ready = rdy;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        modelReset();
        #1 rst = 1'b1;
        #1 checkOutput("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic run: 5 vs 3 spikes, neuron 1 wins.
        applyStimulus("t1.start", 0, 0, 0, 0, 1, 0);
        repeat (3) applyStimulus("t1.both", 1, 1, 0, 0, 0, 0);
        repeat (2) applyStimulus("t1.n1", 1, 0, 0, 0, 0, 0);
        applyStimulus("t1.done", 0, 0, 0, 1, 0, 0);
        check("t1.valid", valid_b, 1);
        check("t1.count1", c1_b, 5);
        check("t1.count2", c2_b, 3);
        check("t1.class", cls_b, 2'b01);
        applyStimulus("t1.ready", 0, 0, 0, 0, 0, 1);
        check("t1.valid_drop", valid_b, 0);
        check("t1.busy_drop", busy_b, 0);

        // Hold masks neuron-1 spikes; neuron 2 wins.
        applyStimulus("t2.start", 0, 0, 0, 0, 1, 0);
        repeat (2) applyStimulus("t2.hold", 1, 0, 1, 0, 0, 0);
        repeat (2) applyStimulus("t2.both", 1, 1, 0, 0, 0, 0);
        repeat (2) applyStimulus("t2.n2", 0, 1, 0, 0, 0, 0);
        applyStimulus("t2.done", 0, 0, 0, 1, 0, 0);
        check("t2.count1", c1_b, 2);
        check("t2.count2", c2_b, 4);
        check("t2.class", cls_b, 2'b10);
        applyStimulus("t2.ready", 0, 0, 0, 0, 0, 1);

        // Spikes on both lines in the done cycle are counted.
        applyStimulus("t2b.start", 0, 0, 0, 0, 1, 0);
        applyStimulus("t2b.done", 1, 1, 0, 1, 0, 0);
        check("t2b.count1", c1_a, 1);
        check("t2b.count2", c2_a, 1);
        check("t2b.class", cls_a, 2'b11);
        applyStimulus("t2b.ready", 0, 0, 0, 0, 0, 1);

        // Saturation on the 4-bit instance; the 16-cycle instance times out meanwhile.
        applyStimulus("t3.start", 0, 0, 0, 0, 1, 0);
        repeat (20) applyStimulus("t3.n1", 1, 0, 0, 0, 0, 0);
        applyStimulus("t3.done", 0, 0, 0, 1, 0, 0);
        check("t3.count1", c1_a, 15);
        check("t3.sat", sat_a, 1);
        check("t3.class", cls_a, 2'b01);
        check("t3.b_count1", c1_b, 16);
        check("t3.b_tout", to_b, 1);
        applyStimulus("t3.ready", 0, 0, 0, 0, 0, 1);
        applyStimulus("t3.restart", 0, 0, 0, 0, 1, 0);
        check("t3.sat_clear", sat_a, 0);
        applyStimulus("t3.done2", 0, 0, 0, 1, 0, 0);
        applyStimulus("t3.ready2", 0, 0, 0, 0, 0, 1);

        // Timeout with no spikes: valid in the 17th cycle after entering COUNT, class 00.
        applyStimulus("t4.start", 0, 0, 0, 0, 1, 0);
        repeat (15) applyStimulus("t4.idle", 0, 0, 0, 0, 0, 0);
        check("t4.not_yet", valid_b, 0);
        applyStimulus("t4.last", 0, 0, 0, 0, 0, 0);
        check("t4.valid", valid_b, 1);
        check("t4.tout", to_b, 1);
        check("t4.class", cls_b, 2'b00);
        check("t4.a_busy", busy_a, 1);
        applyStimulus("t4.done", 0, 0, 0, 1, 0, 0);
        check("t4.a_class", cls_a, 2'b00);
        check("t4.a_tout", to_a, 0);
        applyStimulus("t4.ready", 0, 0, 0, 0, 0, 1);

        // Inputs toggling in REPORT without ready leave the result untouched.
        applyStimulus("t5.start", 0, 0, 0, 0, 1, 0);
        repeat (3) applyStimulus("t5.n1", 1, 0, 0, 0, 0, 0);
        applyStimulus("t5.n2", 0, 1, 0, 0, 0, 0);
        applyStimulus("t5.done", 0, 0, 0, 1, 0, 0);
        repeat (10) applyStimulus("t5.stall", 1'($urandom), 1'($urandom), 1'($urandom),
                                  1'($urandom), 1'($urandom), 0);
        check("t5.valid_held", valid_b, 1);
        check("t5.count1_held", c1_b, 3);
        check("t5.class_held", cls_b, 2'b01);
        applyStimulus("t5.ready", 0, 0, 0, 0, 0, 1);
        check("t5.valid_drop", valid_b, 0);
        applyStimulus("t5.after", 0, 0, 0, 0, 0, 1);

        // Asynchronous reset mid-run, then a clean run from zero.
        applyStimulus("t6.start", 0, 0, 0, 0, 1, 0);
        repeat (7) applyStimulus("t6.n1", 1, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 modelReset();
        checkOutput("t6.async");
        check("t6.count1_zero", c1_a, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus("t6.start2", 0, 0, 0, 0, 1, 0);
        repeat (3) applyStimulus("t6.n1b", 1, 0, 0, 0, 0, 0);
        applyStimulus("t6.done", 0, 0, 0, 1, 0, 0);
        check("t6.count1", c1_a, 3);
        applyStimulus("t6.ready", 0, 0, 0, 0, 0, 1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus("rand", 1'($urandom), 1'($urandom),
                          ($urandom_range(3, 0) == 0), ($urandom_range(9, 0) == 0),
                          ($urandom_range(7, 0) == 0), ($urandom_range(2, 0) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snn_output_decoder.md
Name: snn_output_decoder

Overview:
- Reads the two output-neuron spike lines (opnu1, opnu2) and the hold/done status that the SNN core drives.
- Counts spikes per neuron over one inference run and decides the winning class at end of run.
- Presents the result to the host/display side over a valid/ready handshake.
- Sits downstream of the SNN core inside the FPGA top level, at the consuming end of the status interface that the core drives to LEDs.

Parameters:
- CNT_W, 8: width of each per-neuron spike counter; counters saturate at 2^CNT_W-1.
- TIMEOUT, 4096: maximum cycles spent in COUNT without done before a forced report; 0 disables the timeout.
- TO_W, 13: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- run_start  in  1  single-cycle pulse that starts a counting window.
- opnu1_spike  in  1  output neuron 1 spike; one cycle high counts as one spike.
- opnu2_spike  in  1  output neuron 2 spike.
- hold  in  1  core paused; spikes are not counted while high.
- done  in  1  core finished run; level, sampled only in COUNT.
- result_valid  out  1  result fields are stable and valid.
- result_ready  in  1  consumer accepts the result.
- result_class  out  2  00 no spikes, 01 neuron1 wins, 10 neuron2 wins, 11 tie (nonzero).
- count1  out  CNT_W  neuron 1 spike count.
- count2  out  CNT_W  neuron 2 spike count.
- saturated  out  1  either counter hit its maximum during the run.
- timed_out  out  1  report forced by the timeout, not by done.
- busy  out  1  high in COUNT and REPORT.

Behaviour:
- Reset (asynchronous): state=IDLE. All outputs 0: result_valid, result_class, count1, count2, saturated, timed_out, busy. Timeout counter 0. Reset mid-run abandons the run; no result is produced.
- FSM states: IDLE, COUNT, REPORT.
- IDLE:
  - Spikes, hold and done are ignored.
  - On run_start, clear count1, count2, saturated, timed_out, result_class and the timeout counter; go to COUNT next cycle. busy=1 from that edge.
  - Last result fields stay visible in IDLE until the next run_start.
- COUNT:
  - Each cycle with hold=0: count1 += opnu1_spike and count2 += opnu2_spike, independently. Both spikes in the same cycle increment both counters.
  - Saturation: an increment at max holds the value and sets saturated, which is sticky until the next run_start.
  - hold=1 freezes both counters and the timeout counter.
  - done=1 in cycle N:
    - spikes in cycle N are counted if hold=0;
    - go to REPORT; result_valid=1 and result_class valid at N+1;
    - class is computed from the final counts, including cycle N.
  - Timeout counter increments each non-hold cycle. When it reaches TIMEOUT with done=0, go to REPORT with timed_out=1. done has priority if both occur in the same cycle.
  - run_start in COUNT is ignored and does not restart the run.
- REPORT:
  - result_valid=1. count1, count2, result_class, saturated and timed_out are held stable.
  - Transfer occurs on result_valid & result_ready. Next cycle: result_valid=0, busy=0, state IDLE.
  - result_ready may be held high early; the transfer then completes in the first REPORT cycle (one-cycle valid pulse).
  - Spikes, done, hold and run_start are ignored in REPORT.
- Class rule, unsigned compare of the final counts:
  - c1=c2=0 -> 00
  - c1>c2 -> 01
  - c2>c1 -> 10
  - c1=c2≠0 -> 11
  - A saturated tie at max reports 11 with saturated=1.
- Latency: done to result_valid is 1 cycle. run_start to first countable cycle is 1 cycle.

Test Plan:
- Reset, then run_start. Give 5 opnu1 and 3 opnu2 pulses with hold=0, then done -> result_valid 1 cycle after done; count1=5, count2=3, class=01. Raise ready -> valid drops next cycle, busy=0.
- 4 spikes on each neuron, with 2 of the opnu1 spikes during hold=1; then done -> count1=2, count2=4, class=10. Also: spikes on both lines in one cycle plus done in that cycle -> both counted, class from the updated counts.
- CNT_W=4: 20 opnu1 pulses, 0 opnu2, then done -> count1=15, saturated=1, class=01. A fresh run_start clears saturated.
- TIMEOUT=16, no done, no hold -> result_valid at cycle 17 after entry to COUNT with timed_out=1. A run with zero spikes reports class=00.
- Hold result_ready=0 for 10 cycles in REPORT while toggling spikes, done and run_start -> outputs unchanged and valid stays high. Then assert ready -> single transfer.
- Assert rst mid-COUNT after 7 spikes -> all outputs 0 immediately (asynchronous). Then a new run counts from 0.
